// File: rtl/player_action_ctrl_if.sv
// Button/frame-tick inputs and movement/attack outputs of one player's action sequencer.
interface player_action_ctrl_if;
  logic       SCEN;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic       btn_atk1;
  logic       btn_atk2;
  logic       hit_in;
  logic       jump_active;
  logic       move_enable;
  logic       move_left;
  logic       move_right;
  logic       jump;
  logic       attack_active;
  logic [1:0] attack_type;
  logic       attack_busy;
  logic       hitstun;
  logic [2:0] state;

  modport master (
    output SCEN, btn_left, btn_right, btn_jump, btn_atk1, btn_atk2, hit_in, jump_active,
    input  move_enable, move_left, move_right, jump, attack_active, attack_type,
           attack_busy, hitstun, state
  );

  modport slave (
    input  SCEN, btn_left, btn_right, btn_jump, btn_atk1, btn_atk2, hit_in, jump_active,
    output move_enable, move_left, move_right, jump, attack_active, attack_type,
           attack_busy, hitstun, state
  );
endinterface

// File: rtl/player_action_ctrl.sv
// Per-player action sequencer: walk/jump/attack/hit-stun arbitration once per frame tick.
// Define PLAYER_ATK2_EN to enable the attack 2 path; otherwise btn_atk2 is ignored.
module player_action_ctrl #(
  parameter int ATK1_STARTUP   = 3,
  parameter int ATK1_ACTIVE    = 4,
  parameter int ATK1_RECOVERY  = 6,
  parameter int ATK2_STARTUP   = 5,
  parameter int ATK2_ACTIVE    = 6,
  parameter int ATK2_RECOVERY  = 10,
  parameter int HITSTUN_FRAMES = 12
) (
  input logic                  clk,
  input logic                  reset_n,
  player_action_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STARTUP  = 3'd1,
    ACTIVE   = 3'd2,
    RECOVERY = 3'd3,
    HITSTUN  = 3'd4
  } state_e;

  localparam logic [4:0] HIT_LOAD = 5'(HITSTUN_FRAMES - 1);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic       hit_pending_q, hit_pending_d;
  logic       prev_atk1_q;
  logic       atk1_req;
  logic       atk2_req;
  logic       hit_now;

  // Counter reload values are the phase length minus one, so a phase spans exactly N ticks.
  function automatic logic [4:0] startup_load(input logic [1:0] sel);
    return (sel == 2'd2) ? 5'(ATK2_STARTUP - 1) : 5'(ATK1_STARTUP - 1);
  endfunction

  function automatic logic [4:0] active_load(input logic [1:0] sel);
    return (sel == 2'd2) ? 5'(ATK2_ACTIVE - 1) : 5'(ATK1_ACTIVE - 1);
  endfunction

  function automatic logic [4:0] recovery_load(input logic [1:0] sel);
    return (sel == 2'd2) ? 5'(ATK2_RECOVERY - 1) : 5'(ATK1_RECOVERY - 1);
  endfunction

  assign atk1_req = bus.btn_atk1 & ~prev_atk1_q & ~bus.jump_active;

`ifdef PLAYER_ATK2_EN
  logic prev_atk2_q;
  assign atk2_req = bus.btn_atk2 & ~prev_atk2_q & ~bus.jump_active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_atk2_q <= 1'b0;
    end else if (bus.SCEN) begin
      prev_atk2_q <= bus.btn_atk2;
    end
  end
`else
  assign atk2_req = 1'b0;
`endif

  // A hit arriving on the tick itself is consumed immediately.
  assign hit_now = hit_pending_q | bus.hit_in;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    hit_pending_d = hit_pending_q | bus.hit_in;
    if (bus.SCEN) begin
      if (hit_now) begin
        hit_pending_d = 1'b0;
        state_d       = HITSTUN;
        cnt_d         = HIT_LOAD;
        sel_d         = 2'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (atk1_req) begin
              state_d = STARTUP;
              sel_d   = 2'd1;
              cnt_d   = startup_load(2'd1);
            end else if (atk2_req) begin
              state_d = STARTUP;
              sel_d   = 2'd2;
              cnt_d   = startup_load(2'd2);
            end
          end
          STARTUP: begin
            if (cnt_q != 5'd0) begin
              cnt_d = cnt_q - 5'd1;
            end else begin
              state_d = ACTIVE;
              cnt_d   = active_load(sel_q);
            end
          end
          ACTIVE: begin
            if (cnt_q != 5'd0) begin
              cnt_d = cnt_q - 5'd1;
            end else begin
              state_d = RECOVERY;
              cnt_d   = recovery_load(sel_q);
            end
          end
          RECOVERY: begin
            if (cnt_q != 5'd0) begin
              cnt_d = cnt_q - 5'd1;
            end else begin
              state_d = IDLE;
              sel_d   = 2'd0;
            end
          end
          HITSTUN: begin
            if (cnt_q != 5'd0) begin
              cnt_d = cnt_q - 5'd1;
            end else begin
              state_d = IDLE;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = 5'd0;
            sel_d   = 2'd0;
          end
        endcase
      end
    end
  end

  // Previous button level only moves on ticks, so a held button never re-triggers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= 5'd0;
      sel_q         <= 2'd0;
      hit_pending_q <= 1'b0;
      prev_atk1_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      hit_pending_q <= hit_pending_d;
      if (bus.SCEN) begin
        prev_atk1_q <= bus.btn_atk1;
      end
    end
  end

  assign bus.move_enable   = (state_q == IDLE);
  assign bus.move_left     = bus.btn_left & bus.move_enable & ~bus.btn_right;
  assign bus.move_right    = bus.btn_right & bus.move_enable & ~bus.btn_left;
  assign bus.jump          = bus.btn_jump & bus.move_enable;
  assign bus.attack_busy   = (state_q == STARTUP) || (state_q == ACTIVE) || (state_q == RECOVERY);
  assign bus.attack_active = (state_q == ACTIVE);
  assign bus.attack_type   = bus.attack_busy ? sel_q : 2'd0;
  assign bus.hitstun       = (state_q == HITSTUN);
  assign bus.state         = state_q;

endmodule
